// File: rtl/mem_region_decoder.sv
// Registered address decoder: maps a CPU virtual address onto one of NREG regions,
// flags unmapped/misaligned/read-only-write faults and keeps a sticky first-fault record.
module mem_region_decoder #(
    parameter int                  NREG         = 4,
    parameter int                  PADDR_W      = 13,
    parameter logic [NREG*32-1:0]  REGION_BASE  = {32'hFFFF0000, 32'h0000B800, 32'h7FFFEFFC, 32'h10010000},
    parameter logic [NREG*32-1:0]  REGION_LIMIT = {32'hFFFF000C, 32'h0000CACF, 32'h7FFFFFFB, 32'h10010FFF},
    parameter logic [NREG-1:0]     REGION_RO    = 4'b0000,
    localparam int                 BANK_W       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic [31:0]        virtualAddress,
    input  logic [1:0]         accSize,
    input  logic               excAck,
    output logic [PADDR_W-1:0] physicalAddress,
    output logic [NREG-1:0]    memEn,
    output logic [BANK_W-1:0]  memBank,
    output logic               accValid,
    output logic               invalidAddress,
    output logic               excValid,
    output logic [1:0]         excCause,
    output logic [31:0]        badVAddr,
    output logic               excOverflow,
    output logic [7:0]         faultCount
);

    logic               w_req;
    logic               w_hit;
    logic [BANK_W-1:0]  w_idx;
    logic [NREG-1:0]    w_en;
    logic [PADDR_W-1:0] w_off;
    logic               w_ro;
    logic               w_misalign;
    logic               w_fault;
    logic               w_good;
    logic [1:0]         w_cause;

    logic [PADDR_W-1:0] r_pa;
    logic [NREG-1:0]    r_en;
    logic [BANK_W-1:0]  r_bank;
    logic               r_acc;
    logic               r_inv;
    logic               r_exc_valid;
    logic [1:0]         r_exc_cause;
    logic [31:0]        r_bad_vaddr;
    logic               r_exc_ovf;
    logic [7:0]         r_fault_cnt;

    assign w_req = memRead | memWrite;

    // Lowest-index region wins on overlap: later matches are ignored once w_hit is set.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_en  = '0;
        w_off = '0;
        w_ro  = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (!w_hit &&
                virtualAddress >= REGION_BASE[32*i +: 32] &&
                virtualAddress <= REGION_LIMIT[32*i +: 32]) begin
                w_hit   = 1'b1;
                w_idx   = BANK_W'(i);
                w_en[i] = 1'b1;
                w_off   = PADDR_W'(virtualAddress - REGION_BASE[32*i +: 32]);
                w_ro    = REGION_RO[i];
            end
        end
    end

    always_comb begin
        case (accSize)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = virtualAddress[0];
            default: w_misalign = virtualAddress[1] | virtualAddress[0];
        endcase
    end

    assign w_fault = w_req & (~w_hit | w_misalign | (memWrite & w_ro));
    assign w_good  = w_req & ~w_fault;
    assign w_cause = !w_hit ? 2'b01 : (w_misalign ? 2'b10 : 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pa   <= '0;
            r_en   <= '0;
            r_bank <= '0;
            r_acc  <= 1'b0;
            r_inv  <= 1'b0;
        end else begin
            r_pa   <= w_good ? w_off : '0;
            r_en   <= w_good ? w_en  : '0;
            r_bank <= w_good ? w_idx : '0;
            r_acc  <= w_good;
            r_inv  <= w_fault;
        end
    end

    // A fault arriving with excAck is treated as a fresh first fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= '0;
            r_bad_vaddr <= '0;
            r_exc_ovf   <= 1'b0;
        end else if (w_fault && (!r_exc_valid || excAck)) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= w_cause;
            r_bad_vaddr <= virtualAddress;
            r_exc_ovf   <= 1'b0;
        end else if (w_fault) begin
            r_exc_ovf   <= 1'b1;
        end else if (excAck) begin
            r_exc_valid <= 1'b0;
            r_exc_ovf   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_cnt <= '0;
        end else if (w_fault && r_fault_cnt != 8'hFF) begin
            r_fault_cnt <= r_fault_cnt + 8'd1;
        end
    end

    assign physicalAddress = r_pa;
    assign memEn           = r_en;
    assign memBank         = r_bank;
    assign accValid        = r_acc;
    assign invalidAddress  = r_inv;
    assign excValid        = r_exc_valid;
    assign excCause        = r_exc_cause;
    assign badVAddr        = r_bad_vaddr;
    assign excOverflow     = r_exc_ovf;
    assign faultCount      = r_fault_cnt;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Bench for mem_region_decoder: vector table plus hand sequences, checked through a
// scoreboard queue one cycle after each drive. A second instance has region 2 read-only.
module tb_mem_region_decoder;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] va;
        logic [3:0]  en;
        logic [1:0]  bank;
        logic [12:0] pa;
        logic        acc;
        logic        inv;
        logic        ev;
        logic [1:0]  cause;
        logic [31:0] bad;
        logic        ovf;
        logic [7:0]  cnt;
        logic        ro_chk;
        logic        ro_acc;
        logic        ro_inv;
        logic [1:0]  ro_cause;
        logic [12:0] ro_pa;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] virtualAddress = '0;
    logic [1:0]  accSize = '0;
    logic        excAck = 1'b0;

    logic [12:0] physicalAddress, ro_pa;
    logic [3:0]  memEn, ro_en;
    logic [1:0]  memBank, ro_bank;
    logic        accValid, ro_acc;
    logic        invalidAddress, ro_inv;
    logic        excValid, ro_ev;
    logic [1:0]  excCause, ro_cause;
    logic [31:0] badVAddr, ro_bad;
    logic        excOverflow, ro_ovf;
    logic [7:0]  faultCount, ro_cnt;

    int checks = 0;
    int failures = 0;
    vec_t sb_q[$];

    always #5 clk = ~clk;

    mem_region_decoder u_dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .virtualAddress(virtualAddress), .accSize(accSize), .excAck(excAck),
        .physicalAddress(physicalAddress), .memEn(memEn), .memBank(memBank),
        .accValid(accValid), .invalidAddress(invalidAddress), .excValid(excValid),
        .excCause(excCause), .badVAddr(badVAddr), .excOverflow(excOverflow),
        .faultCount(faultCount)
    );

    mem_region_decoder #(.REGION_RO(4'b0100)) u_ro (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .virtualAddress(virtualAddress), .accSize(accSize), .excAck(excAck),
        .physicalAddress(ro_pa), .memEn(ro_en), .memBank(ro_bank),
        .accValid(ro_acc), .invalidAddress(ro_inv), .excValid(ro_ev),
        .excCause(ro_cause), .badVAddr(ro_bad), .excOverflow(ro_ovf),
        .faultCount(ro_cnt)
    );

    function automatic vec_t mk(input logic r, input logic a, input logic rd, input logic wr,
                                input logic [1:0] sz, input logic [31:0] va,
                                input logic [3:0] en, input logic [1:0] bank, input logic [12:0] pa,
                                input logic acc, input logic inv, input logic ev,
                                input logic [1:0] cause, input logic [31:0] bad,
                                input logic ovf, input logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.ack = a; v.rd = rd; v.wr = wr; v.sz = sz; v.va = va;
        v.en = en; v.bank = bank; v.pa = pa; v.acc = acc; v.inv = inv;
        v.ev = ev; v.cause = cause; v.bad = bad; v.ovf = ovf; v.cnt = cnt;
        v.ro_chk = 1'b0; v.ro_acc = 1'b0; v.ro_inv = 1'b0; v.ro_cause = '0; v.ro_pa = '0;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst = v.rst; excAck = v.ack; memRead = v.rd; memWrite = v.wr;
        accSize = v.sz; virtualAddress = v.va;
        sb_q.push_back(v);
    endtask

    int step = 0;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            vec_t e;
            e = sb_q.pop_front();
            chk("memEn", step, 32'(memEn), 32'(e.en));
            chk("memBank", step, 32'(memBank), 32'(e.bank));
            chk("physicalAddress", step, 32'(physicalAddress), 32'(e.pa));
            chk("accValid", step, 32'(accValid), 32'(e.acc));
            chk("invalidAddress", step, 32'(invalidAddress), 32'(e.inv));
            chk("excValid", step, 32'(excValid), 32'(e.ev));
            chk("excCause", step, 32'(excCause), 32'(e.cause));
            chk("badVAddr", step, badVAddr, e.bad);
            chk("excOverflow", step, 32'(excOverflow), 32'(e.ovf));
            chk("faultCount", step, 32'(faultCount), 32'(e.cnt));
            if (e.ro_chk) begin
                chk("ro_accValid", step, 32'(ro_acc), 32'(e.ro_acc));
                chk("ro_invalidAddress", step, 32'(ro_inv), 32'(e.ro_inv));
                chk("ro_excCause", step, 32'(ro_cause), 32'(e.ro_cause));
                chk("ro_physicalAddress", step, 32'(ro_pa), 32'(e.ro_pa));
            end
            step++;
        end
    end

    vec_t tbl[$];
    vec_t v;

    initial begin
        // reset with a pending request: discarded
        drive(mk(1,0,1,0,2'b10,32'h10010008, 4'h0,2'd0,13'h0,0,0, 0,2'd0,32'h0,0,8'd0));

        tbl.push_back(mk(0,0,1,0,2'b10,32'h10010008, 4'h1,2'd0,13'h008,1,0, 0,2'd0,32'h0,0,8'd0));
        tbl.push_back(mk(0,0,0,1,2'b01,32'h0000CACE, 4'h4,2'd2,13'h12CE,1,0, 0,2'd0,32'h0,0,8'd0));
        tbl.push_back(mk(0,0,0,1,2'b01,32'h0000CAD0, 4'h0,2'd0,13'h0,0,1, 1,2'd1,32'h0000CAD0,0,8'd1));
        tbl.push_back(mk(0,1,0,0,2'b00,32'h0,        4'h0,2'd0,13'h0,0,0, 0,2'd1,32'h0000CAD0,0,8'd1));
        tbl.push_back(mk(0,0,1,0,2'b10,32'h7FFFEFFE, 4'h0,2'd0,13'h0,0,1, 1,2'd2,32'h7FFFEFFE,0,8'd2));
        tbl.push_back(mk(0,0,1,0,2'b00,32'h00000000, 4'h0,2'd0,13'h0,0,1, 1,2'd2,32'h7FFFEFFE,1,8'd3));
        tbl.push_back(mk(0,1,1,0,2'b00,32'h12345678, 4'h0,2'd0,13'h0,0,1, 1,2'd1,32'h12345678,0,8'd4));
        tbl.push_back(mk(0,1,0,0,2'b00,32'h0,        4'h0,2'd0,13'h0,0,0, 0,2'd1,32'h12345678,0,8'd4));
        tbl.push_back(mk(0,0,1,0,2'b10,32'hFFFF000C, 4'h8,2'd3,13'h00C,1,0, 0,2'd1,32'h12345678,0,8'd4));
        tbl.push_back(mk(0,0,1,0,2'b00,32'hFFFF000D, 4'h0,2'd0,13'h0,0,1, 1,2'd1,32'hFFFF000D,0,8'd5));
        tbl.push_back(mk(0,1,1,0,2'b01,32'h7FFFEFFC, 4'h2,2'd1,13'h0,1,0, 0,2'd1,32'hFFFF000D,0,8'd5));
        tbl.push_back(mk(0,0,1,0,2'b11,32'h7FFFFFFA, 4'h0,2'd0,13'h0,0,1, 1,2'd2,32'h7FFFFFFA,0,8'd6));
        tbl.push_back(mk(0,0,1,1,2'b01,32'h10010FFE, 4'h1,2'd0,13'h0FFE,1,0, 1,2'd2,32'h7FFFFFFA,0,8'd6));
        tbl.push_back(mk(0,0,0,0,2'b10,32'h10010000, 4'h0,2'd0,13'h0,0,0, 1,2'd2,32'h7FFFFFFA,0,8'd6));
        tbl.push_back(mk(0,0,0,1,2'b01,32'h0000B801, 4'h0,2'd0,13'h0,0,1, 1,2'd2,32'h7FFFFFFA,1,8'd7));
        tbl.push_back(mk(0,0,1,0,2'b00,32'h0000B7FF, 4'h0,2'd0,13'h0,0,1, 1,2'd2,32'h7FFFFFFA,1,8'd8));
        tbl.push_back(mk(0,0,1,0,2'b00,32'h0000CACF, 4'h4,2'd2,13'h12CF,1,0, 1,2'd2,32'h7FFFFFFA,1,8'd8));
        foreach (tbl[i]) drive(tbl[i]);

        // reset mid-run with a request present, then read-only region checks
        drive(mk(1,0,1,0,2'b00,32'h0000B800, 4'h0,2'd0,13'h0,0,0, 0,2'd0,32'h0,0,8'd0));
        v = mk(0,0,0,1,2'b00,32'h0000B800, 4'h4,2'd2,13'h0,1,0, 0,2'd0,32'h0,0,8'd0);
        v.ro_chk = 1'b1; v.ro_acc = 1'b0; v.ro_inv = 1'b1; v.ro_cause = 2'd3; v.ro_pa = '0;
        drive(v);
        v = mk(0,0,1,0,2'b00,32'h0000B800, 4'h4,2'd2,13'h0,1,0, 0,2'd0,32'h0,0,8'd0);
        v.ro_chk = 1'b1; v.ro_acc = 1'b1; v.ro_inv = 1'b0; v.ro_cause = 2'd3; v.ro_pa = '0;
        drive(v);

        // 300 back-to-back faults: counter saturates at 255
        for (int n = 1; n <= 300; n++) begin
            drive(mk(0,0,1,0,2'b00,32'h00000000, 4'h0,2'd0,13'h0,0,1, 1,2'd1,32'h0,
                     (n >= 2) ? 1'b1 : 1'b0, (n >= 255) ? 8'd255 : 8'(n)));
        end
        drive(mk(1,0,1,0,2'b00,32'h00000000, 4'h0,2'd0,13'h0,0,0, 0,2'd0,32'h0,0,8'd0));
        drive(mk(0,0,1,0,2'b00,32'h00000000, 4'h0,2'd0,13'h0,0,1, 1,2'd1,32'h0,0,8'd1));
        drive(mk(0,0,0,0,2'b00,32'h00000000, 4'h0,2'd0,13'h0,0,0, 1,2'd1,32'h0,0,8'd1));

        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0; excAck = 1'b0; rst = 1'b0;
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
